// File: rtl/config_seq_pkg.sv
// Shared constants and types for the start-up configuration sequencer.
package config_seq_pkg;
  localparam logic [31:0] bus_base = 32'h43C0_0000;

  typedef enum logic [2:0] {IDLE, SETTLE, WRITE, DONE, ERROR} seq_state_t;

  localparam int default_n_writes = 2;
  typedef logic [31:0] offset_tbl_t [default_n_writes-1:0];
  typedef logic [31:0] value_tbl_t [default_n_writes-1:0];

  // Entry 0 is the rightmost element: (offset 0, value 5), then (offset 4, value 32).
  localparam offset_tbl_t default_offsets = '{32'd4, 32'd0};
  localparam value_tbl_t default_values = '{32'd32, 32'd5};
endpackage

// File: rtl/config_sequencer_timeout_counter.sv
// Loadable down-counter; terminal flags the last cycle before the count hits zero.
module timeout_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             terminal
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)                        count <= '0;
    else if (clear)                   count <= '0;
    else if (load)                    count <= value;
    else if (enable && count != '0)   count <= count - WIDTH'(1);
  end

  assign terminal = (count == WIDTH'(1));
endmodule

// File: rtl/config_sequencer.sv
// Walks a parameter table and issues one bus write per entry after reset or start.
module config_sequencer
  import config_seq_pkg::*;
#(
  parameter int                    N_WRITES       = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BUS_BASE       = ADDR_WIDTH'(bus_base),
  parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSETS [N_WRITES-1:0] = default_offsets,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUES  [N_WRITES-1:0] = default_values,
  parameter int                    SETTLE_CYCLES  = 4,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter bit                    AUTO_START     = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [$clog2(N_WRITES+1)-1:0]   error_index,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_valid,
  input  logic                            wr_ready
);
  localparam int IDX_W   = $clog2(N_WRITES + 1);
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n, idx_inc, err_n;
  logic boot;
  logic wr_valid_n;
  logic [ADDR_WIDTH-1:0] addr_n, tbl_addr, first_addr;
  logic [DATA_WIDTH-1:0] data_n, tbl_data, first_data;
  logic settle_load, settle_en, settle_tc;
  logic to_load, to_en, to_tc, cnt_clear;
  logic launch, enter_write, last;

  assign idx_inc    = idx + IDX_W'(1);
  assign last       = (idx == IDX_W'(N_WRITES - 1));
  assign first_addr = BUS_BASE + ADDR_OFFSETS[0];
  assign first_data = INIT_VALUES[0];

  // Lookup of the entry that follows the current one; address wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    tbl_addr = '0;
    tbl_data = '0;
    for (int k = 0; k < N_WRITES; k++) begin
      if (idx_inc == IDX_W'(k)) begin
        tbl_addr = BUS_BASE + ADDR_OFFSETS[k];
        tbl_data = INIT_VALUES[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      boot        <= 1'b1;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      error_index <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      boot        <= 1'b0;
      wr_valid    <= wr_valid_n;
      wr_addr     <= addr_n;
      wr_data     <= data_n;
      error_index <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    err_n       = error_index;
    wr_valid_n  = wr_valid;
    addr_n      = wr_addr;
    data_n      = wr_data;
    settle_load = 1'b0;
    settle_en   = 1'b0;
    to_load     = 1'b0;
    to_en       = 1'b0;
    launch      = 1'b0;
    enter_write = 1'b0;

    case (state)
      IDLE:        launch = start || (AUTO_START && boot);
      DONE, ERROR: launch = start;
      SETTLE: begin
        settle_en = 1'b1;
        if (settle_tc) enter_write = 1'b1;
      end
      WRITE: begin
        if (wr_valid && wr_ready) begin
          if (last) begin
            state_n    = DONE;
            wr_valid_n = 1'b0;
          end else begin
            idx_n   = idx_inc;
            addr_n  = tbl_addr;
            data_n  = tbl_data;
            to_load = 1'b1;
          end
        end else begin
          to_en = 1'b1;
          if (to_tc) begin
            state_n    = ERROR;
            wr_valid_n = 1'b0;
            err_n      = idx;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      idx_n = '0;
      err_n = '0;
      if (SETTLE_CYCLES == 0) begin
        enter_write = 1'b1;
      end else begin
        state_n     = SETTLE;
        settle_load = 1'b1;
      end
    end

    // Entering WRITE always presents entry 0, since idx is zero on every launch.
    if (enter_write) begin
      state_n    = WRITE;
      wr_valid_n = 1'b1;
      addr_n     = first_addr;
      data_n     = first_data;
      to_load    = 1'b1;
    end

    cnt_clear = !(state_n == SETTLE || state_n == WRITE);
  end

  timeout_counter #(.WIDTH(CNT_W)) u_settle (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .load    (settle_load),
    .enable  (settle_en),
    .value   (CNT_W'(SETTLE_CYCLES)),
    .terminal(settle_tc)
  );

  timeout_counter #(.WIDTH(CNT_W)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .load    (to_load),
    .enable  (to_en),
    .value   (CNT_W'(TIMEOUT_CYCLES)),
    .terminal(to_tc)
  );

  assign busy  = (state == SETTLE) || (state == WRITE);
  assign done  = (state == DONE);
  assign error = (state == ERROR);
endmodule

// File: tb/tb_config_sequencer.sv
// Bench: default instance (auto start, settle 4) and a fast instance (manual start, settle 0, timeout 8).
module tb_config_sequencer;
  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0, ready_a = 1'b1;
  logic        busy_a, done_a, error_a, wr_valid_a;
  logic [1:0]  error_index_a;
  logic [31:0] wr_addr_a, wr_data_a;

  logic        rst_b = 1'b1, start_b = 1'b0, ready_b = 1'b0;
  logic        busy_b, done_b, error_b, wr_valid_b;
  logic [1:0]  error_index_b;
  logic [31:0] wr_addr_b, wr_data_b;

  config_sequencer dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .error(error_a), .error_index(error_index_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(ready_a)
  );

  config_sequencer #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .error(error_b), .error_index(error_index_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(ready_b)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic rdy; logic [3:0] flags; logic [31:0] addr; } vec_t;

  wr_t q_a[$], q_b[$];
  int total = 0, bad = 0, hs_a = 0, hs_b = 0;

  function automatic wr_t entry(input int k);
    wr_t e;
    e.a = (k == 0) ? BASE : BASE + 32'd4;
    e.d = (k == 0) ? 32'd5 : 32'd32;
    return e;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitors: inputs settle 1 unit after the rising edge, so negedge sees what the next edge will.
  always @(negedge clk) begin
    if (!rst_a && wr_valid_a && ready_a) begin
      hs_a++;
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_a_extra: got addr=%0h data=%0h want no write", wr_addr_a, wr_data_a);
      end else begin
        wr_t e;
        e = q_a.pop_front();
        check("wr_a", {wr_addr_a, wr_data_a}, {e.a, e.d});
      end
    end
    if (!rst_b && wr_valid_b && ready_b) begin
      hs_b++;
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_b_extra: got addr=%0h data=%0h want no write", wr_addr_b, wr_data_b);
      end else begin
        wr_t e;
        e = q_b.pop_front();
        check("wr_b", {wr_addr_b, wr_data_b}, {e.a, e.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t boot_vec [8];
    int hs0, n;
    // flags = {busy, wr_valid, done, error}
    for (int i = 0; i < 4; i++) boot_vec[i] = '{1'b1, 4'b1000, 32'h0};
    boot_vec[4] = '{1'b1, 4'b1100, BASE};
    boot_vec[5] = '{1'b1, 4'b1100, BASE + 32'd4};
    boot_vec[6] = '{1'b1, 4'b0010, 32'h0};
    boot_vec[7] = '{1'b1, 4'b0010, 32'h0};

    repeat (3) tick();
    check("rst_a_flags", {busy_a, done_a, error_a, wr_valid_a, error_index_a}, 6'd0);
    check("rst_a_bus", {wr_addr_a, wr_data_a}, 64'd0);
    check("rst_b_flags", {busy_b, done_b, error_b, wr_valid_b, error_index_b}, 6'd0);

    // Auto start after reset, ready tied high
    q_a.push_back(entry(0));
    q_a.push_back(entry(1));
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ready_a = boot_vec[i].rdy;
      tick();
      check($sformatf("boot_%0d", i), {busy_a, wr_valid_a, done_a, error_a}, boot_vec[i].flags);
      if (boot_vec[i].flags[2]) check($sformatf("boot_addr_%0d", i), wr_addr_a, boot_vec[i].addr);
    end
    check("boot_hs", hs_a, 2);

    // Backpressure: ten cycles of ready low on entry 0
    hs0 = hs_a;
    ready_a = 1'b0;
    q_a.push_back(entry(0));
    q_a.push_back(entry(1));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("bp_start", {busy_a, done_a}, 2'b10);
    n = 0;
    while (!wr_valid_a && n < 10) begin tick(); n++; end
    check("bp_valid_latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold_%0d", k), {error_a, wr_valid_a, wr_addr_a, wr_data_a}, {1'b0, 1'b1, BASE, 32'd5});
      tick();
    end
    ready_a = 1'b1;
    n = 0;
    while (!done_a && n < 10) begin tick(); n++; end
    check("bp_done", {done_a, error_a, busy_a}, 3'b100);
    check("bp_hs", hs_a - hs0, 2);

    // Manual-start instance: nothing happens until start
    rst_b = 1'b0;
    repeat (4) tick();
    check("b_noauto", {busy_b, wr_valid_b}, 2'b00);

    // Timeout on entry 0
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_to_first", {busy_b, wr_valid_b, wr_addr_b}, {1'b1, 1'b1, BASE});
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("b_to_wait_%0d", k), {wr_valid_b, error_b}, 2'b10);
    end
    tick();
    check("b_to_err", {error_b, wr_valid_b, done_b, busy_b, error_index_b}, {4'b1000, 2'd0});

    // Restart from ERROR; a second start while busy must be ignored
    hs0 = hs_b;
    ready_b = 1'b1;
    q_b.push_back(entry(0));
    q_b.push_back(entry(1));
    start_b = 1'b1;
    tick();
    check("b_rs_first", {error_b, done_b, wr_valid_b, wr_addr_b, wr_data_b}, {3'b001, BASE, 32'd5});
    tick();
    start_b = 1'b0;
    check("b_rs_second", {wr_valid_b, wr_addr_b, wr_data_b}, {1'b1, BASE + 32'd4, 32'd32});
    tick();
    check("b_rs_done", {done_b, busy_b, wr_valid_b}, 3'b100);
    repeat (3) tick();
    check("b_rs_hs", hs_b - hs0, 2);
    check("b_rs_hold", {done_b, busy_b}, 2'b10);

    // Timeout on entry 1 latches error_index 1
    q_b.push_back(entry(0));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    ready_b = 1'b0;
    check("b_to1_entry", {wr_valid_b, wr_addr_b}, {1'b1, BASE + 32'd4});
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("b_to1_wait_%0d", k), {error_b, wr_addr_b, wr_data_b}, {1'b0, BASE + 32'd4, 32'd32});
    end
    tick();
    check("b_to1_err", {error_b, wr_valid_b, error_index_b}, {2'b10, 2'd1});

    // Restart clears flags, then reset while entry 1 is pending
    hs0 = hs_b;
    q_b.push_back(entry(0));
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_clr", {error_b, error_index_b, wr_valid_b}, {1'b0, 2'd0, 1'b1});
    tick();
    ready_b = 1'b0;
    check("b_mid_entry1", {wr_valid_b, wr_addr_b}, {1'b1, BASE + 32'd4});
    rst_b = 1'b1;
    tick();
    check("b_midrst_flags", {busy_b, done_b, error_b, wr_valid_b, error_index_b}, 6'd0);
    check("b_midrst_bus", {wr_addr_b, wr_data_b}, 64'd0);
    rst_b = 1'b0;
    repeat (5) tick();
    check("b_idle_after", {busy_b, wr_valid_b, done_b}, 3'b000);
    check("b_midrst_hs", hs_b - hs0, 1);

    q_b.push_back(entry(0));
    q_b.push_back(entry(1));
    ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 5) begin tick(); n++; end
    check("b_final_done", {done_b, error_b}, 2'b10);
    check("b_final_latency", n, 2);

    repeat (2) tick();
    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/config_sequencer.md
# config_sequencer

Sequences start-up configuration of a parameterised datapath block. On start, it walks a parameter table of (address offset, value) pairs. For each pair it issues one write on a simple valid/ready register bus at `BUS_BASE + offset`, then reports completion or timeout. It sits between the bus interconnect and a block whose runtime configuration mirrors its elaboration-time parameters, so a fresh bitstream or a soft reset reloads known-good settings without processor involvement.

## Interface
Parameters:
- `N_WRITES`, 2: number of table entries, ≥1.
- `ADDR_WIDTH`, 32: bus address width.
- `DATA_WIDTH`, 32: bus data width.
- `BUS_BASE`, 32'h43C00000: base address, normally taken from the shared package constant.
- `ADDR_OFFSETS [N_WRITES-1:0]`, '{4, 0}: per-entry offset, `ADDR_WIDTH` bits each.
- `INIT_VALUES [N_WRITES-1:0]`, '{32, 5}: per-entry write data, `DATA_WIDTH` bits each.
- `SETTLE_CYCLES`, 4: idle cycles between start and first write, 0 allowed.
- `TIMEOUT_CYCLES`, 256: maximum wait for `wr_ready` per write, ≥1.
- `AUTO_START`, 1: start automatically after reset deassertion.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle request; honoured in IDLE, DONE or ERROR only.
- `busy`, out, 1: high in SETTLE or WRITE.
- `done`, out, 1: level, high in DONE.
- `error`, out, 1: level, high in ERROR.
- `error_index`, out, `$clog2(N_WRITES+1)`: index of the entry that timed out.
- `wr_addr`, out, `ADDR_WIDTH`: write address.
- `wr_data`, out, `DATA_WIDTH`: write data.
- `wr_valid`, out, 1: write request.
- `wr_ready`, in, 1: target accepts.

## Operation
- FSM states: IDLE, SETTLE, WRITE, DONE, ERROR.
- Reset values: state IDLE, all outputs 0, index 0, counters 0.
- IDLE → SETTLE on `start`, or on the first cycle after `reset` falls when `AUTO_START`=1. The counter loads `SETTLE_CYCLES`. If `SETTLE_CYCLES`=0, go directly to WRITE.
- SETTLE: decrement each cycle; → WRITE when the count reaches 0.
- WRITE: drive `wr_valid`=1, `wr_addr` = `BUS_BASE + ADDR_OFFSETS[idx]`, `wr_data` = `INIT_VALUES[idx]`.
  - Address addition is modulo 2^`ADDR_WIDTH`; overflow wraps silently.
  - Handshake occurs when `wr_valid && wr_ready` at a clock edge.
    - If `idx == N_WRITES-1`, go → DONE.
    - Otherwise increment `idx`, restart the timeout, and stay in WRITE. Back-to-back writes at one per cycle are allowed.
  - Each cycle without `wr_ready` increments the timeout counter. When it reaches `TIMEOUT_CYCLES`, go → ERROR, drop `wr_valid`, and latch `error_index` = `idx`.
- DONE, ERROR: hold. `start` → SETTLE with `idx` reset to 0 and `done`/`error`/`error_index` cleared.
- `start` while busy is ignored; there is no queueing.
- `reset` in any state returns to IDLE next edge. Any in-flight write is abandoned and `wr_valid` drops.
- Ordering: entries are written in ascending index, 0 first.

## Timing
- `start` at edge N: SETTLE at N+1; `wr_valid` first high at N+1+`SETTLE_CYCLES`.
- `wr_addr`/`wr_data` are registered and stable while `wr_valid` is high. They change only in the cycle after a handshake.
- `wr_valid` never deasserts without a handshake except on timeout or reset.
- Timeout: with `wr_valid` rising at cycle T and `wr_ready` stuck low, `error`=1 and `wr_valid`=0 from cycle T+`TIMEOUT_CYCLES`.
- `done` rises the cycle after the final handshake.
- Minimum total latency from `start` to `done` is `SETTLE_CYCLES` + `N_WRITES` + 1 cycles.

## Structure
- Shared package `config_seq_pkg`: `bus_base` constant, the `seq_state_t` enum, and the default offset/value table typedefs.
- One sub-module, `timeout_counter`: load/clear/enable, terminal-count flag. It is reused for both settle and timeout counting (two instances).
- Table indexing is purely combinational from `idx`. The output registers are updated at handshake.

## Test plan
- Defaults, `AUTO_START`=1, `wr_ready` tied 1: after reset falls, writes (0x43C00000, 5) then (0x43C00004, 32) on consecutive cycles; `done` after 4+2+1 cycles; `busy` low.
- Backpressure: `wr_ready` low for 10 cycles on entry 0. Address and data stay stable throughout; exactly 2 handshakes; `error`=0.
- Timeout: `TIMEOUT_CYCLES`=8, `wr_ready` stuck 0. `error`=1 and `error_index`=0 at T+8; `wr_valid`=0; `done`=0.
- Restart: pulse `start` from ERROR with `wr_ready`=1. Flags clear, full sequence repeats from index 0, ending in `done`=1.
- Reset mid-write: assert `reset` while `wr_valid`=1 on entry 1. Next cycle all outputs are 0 and state is IDLE. With `AUTO_START`=0, no write occurs until `start`.
- `SETTLE_CYCLES`=0 and `start` during busy: `wr_valid` in the cycle after `start`; a second `start` mid-sequence changes nothing.
